// File: rtl/baser_pkg.sv
// Shared BASE-R sync-header encodings, header check and block-lock states.
package baser_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/baser_sh_counter.sv
// Combinational sync-header check over NUM_BLOCKS parallel 66b blocks.
// Zero latency; no flow control, purely a function of the current word.
module baser_sh_counter #(
  parameter int NUM_BLOCKS  = 4,
  parameter int FRAME_WIDTH = 66
) (
  input  logic [NUM_BLOCKS*FRAME_WIDTH-1:0] coded,
  output logic [$clog2(NUM_BLOCKS+1)-1:0]   nv,
  output logic [$clog2(NUM_BLOCKS+1)-1:0]   ni
);
  import baser_pkg::*;

  localparam int CW = $clog2(NUM_BLOCKS + 1);

  always_comb begin
    nv = '0;
    // Sync header occupies the top two bits of each block.
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      if (sh_is_valid(coded[k*FRAME_WIDTH + FRAME_WIDTH - 2 +: 2])) begin
        nv = nv + 1'b1;
      end
    end
    ni = CW'(NUM_BLOCKS) - nv;
  end

endmodule

// File: rtl/baser_66b_lock_monitor.sv
// Block-lock FSM, hi-BER window monitor and header statistics for NUM_BLOCKS 66b blocks/cycle.
// All outputs registered, 1-cycle latency; i_valid=0 cycles freeze all state, no backpressure.
module baser_66b_lock_monitor #(
  parameter int NUM_BLOCKS  = 4,
  parameter int FRAME_WIDTH = 66,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_BAD  = 16,
  parameter int BER_WINDOW  = 1024,
  parameter int BER_THRESH  = 97,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  input  logic [NUM_BLOCKS*FRAME_WIDTH-1:0] i_rx_coded,
  output logic [NUM_BLOCKS*FRAME_WIDTH-1:0] o_rx_coded,
  output logic                              o_valid,
  output logic                              o_block_lock,
  output logic                              o_hi_ber,
  output logic                              o_slip,
  output logic [CNT_WIDTH-1:0]              o_valid_sh_count,
  output logic [CNT_WIDTH-1:0]              o_inv_sh_count,
  output logic [CNT_WIDTH-1:0]              o_lock_loss_count
);
  import baser_pkg::*;

  localparam int CW = $clog2(NUM_BLOCKS + 1);
  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int TW = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
  localparam int EW = $clog2(BER_THRESH + 1);

  if ((LOCK_CNT % NUM_BLOCKS) != 0) begin : g_lock_cnt_check
    $error("LOCK_CNT must be a multiple of NUM_BLOCKS");
  end

  lock_state_t   state;
  logic [SW-1:0] sh_cnt;
  logic [BW-1:0] bad_cnt;
  logic [TW-1:0] ber_timer;
  logic [EW-1:0] ber_cnt;

  logic [CW-1:0] nv;
  logic [CW-1:0] ni;

  baser_sh_counter #(
    .NUM_BLOCKS  (NUM_BLOCKS),
    .FRAME_WIDTH (FRAME_WIDTH)
  ) u_sh_counter (
    .coded (i_rx_coded),
    .nv    (nv),
    .ni    (ni)
  );

  logic [31:0] sh_sum;
  logic [31:0] bad_sum;
  logic [31:0] ber_sum;
  logic        ber_end;

  always_comb begin
    sh_sum  = 32'(sh_cnt) + 32'(NUM_BLOCKS);
    bad_sum = 32'(bad_cnt) + 32'(ni);
    ber_sum = 32'(ber_cnt) + 32'(ni);
    ber_end = (32'(ber_timer) == 32'(BER_WINDOW - 1));
  end

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CW-1:0]        b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign o_block_lock = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state             <= UNLOCKED;
      sh_cnt            <= '0;
      bad_cnt           <= '0;
      ber_timer         <= '0;
      ber_cnt           <= '0;
      o_rx_coded        <= '0;
      o_valid           <= 1'b0;
      o_hi_ber          <= 1'b0;
      o_slip            <= 1'b0;
      o_valid_sh_count  <= '0;
      o_inv_sh_count    <= '0;
      o_lock_loss_count <= '0;
    end else begin
      o_slip  <= 1'b0;
      o_valid <= 1'b0;
      if (i_valid) begin
        o_rx_coded       <= i_rx_coded;
        o_valid_sh_count <= sat_add(o_valid_sh_count, nv);
        o_inv_sh_count   <= sat_add(o_inv_sh_count, ni);
        case (state)
          UNLOCKED: begin
            if (ni != '0) begin
              sh_cnt <= '0;
              o_slip <= 1'b1;
            end else if (sh_sum >= 32'(LOCK_CNT)) begin
              state   <= LOCKED;
              sh_cnt  <= '0;
              bad_cnt <= '0;
              o_valid <= 1'b1;
            end else begin
              sh_cnt <= SW'(sh_sum);
            end
          end
          LOCKED: begin
            // Loss of lock takes priority over a coincident window completion.
            if (bad_sum >= 32'(UNLOCK_BAD)) begin
              state             <= UNLOCKED;
              o_slip            <= 1'b1;
              o_lock_loss_count <= sat_add(o_lock_loss_count, CW'(1));
              sh_cnt            <= '0;
              bad_cnt           <= '0;
              ber_timer         <= '0;
              ber_cnt           <= '0;
              o_hi_ber          <= 1'b0;
            end else begin
              o_valid <= 1'b1;
              if (sh_sum >= 32'(LOCK_CNT)) begin
                sh_cnt  <= '0;
                bad_cnt <= '0;
              end else begin
                sh_cnt  <= SW'(sh_sum);
                bad_cnt <= BW'(bad_sum);
              end
              // ber_cnt saturates at the threshold, so ber_sum >= BER_THRESH also
              // means the threshold was reached earlier in this window.
              if (ber_sum >= 32'(BER_THRESH)) begin
                o_hi_ber <= 1'b1;
              end else if (ber_end) begin
                o_hi_ber <= 1'b0;
              end
              if (ber_end) begin
                ber_timer <= '0;
                ber_cnt   <= '0;
              end else begin
                ber_timer <= ber_timer + 1'b1;
                ber_cnt   <= (ber_sum >= 32'(BER_THRESH)) ? EW'(BER_THRESH) : EW'(ber_sum);
              end
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_baser_66b_lock_monitor.sv
// Directed bench for baser_66b_lock_monitor with a cycle-level reference model.
module tb_baser_66b_lock_monitor;

  localparam int NB         = 4;
  localparam int FW         = 66;
  localparam int LOCK_CNT   = 64;
  localparam int UNLOCK_BAD = 16;
  localparam int BER_WINDOW = 8;
  localparam int BER_THRESH = 5;
  localparam int CNT_WIDTH  = 32;
  localparam int W          = NB * FW;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid = 1'b0;
  logic [W-1:0]         rx_coded = '0;
  logic [W-1:0]         o_rx_coded;
  logic                 o_valid;
  logic                 o_block_lock;
  logic                 o_hi_ber;
  logic                 o_slip;
  logic [CNT_WIDTH-1:0] o_valid_sh_count;
  logic [CNT_WIDTH-1:0] o_inv_sh_count;
  logic [CNT_WIDTH-1:0] o_lock_loss_count;

  always #5 clk = ~clk;

  baser_66b_lock_monitor #(
    .NUM_BLOCKS  (NB),
    .FRAME_WIDTH (FW),
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_BAD  (UNLOCK_BAD),
    .BER_WINDOW  (BER_WINDOW),
    .BER_THRESH  (BER_THRESH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk               (clk),
    .i_rst_n           (rst_n),
    .i_valid           (valid),
    .i_rx_coded        (rx_coded),
    .o_rx_coded        (o_rx_coded),
    .o_valid           (o_valid),
    .o_block_lock      (o_block_lock),
    .o_hi_ber          (o_hi_ber),
    .o_slip            (o_slip),
    .o_valid_sh_count  (o_valid_sh_count),
    .o_inv_sh_count    (o_inv_sh_count),
    .o_lock_loss_count (o_lock_loss_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int slip_cnt = 0;

  // Reference model: counts of blocks seen, not register images.
  bit           m_locked;
  int           m_blocks_in_win, m_bad_in_win, m_ber_cycles, m_ber_bad;
  bit           e_hi, e_valid, e_slip;
  logic [W-1:0] e_coded;
  longint       e_vcnt, e_icnt, e_loss;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [W-1:0] d);
    int nv;
    int ni;
    logic [1:0] sh;
    if (!r) begin
      m_locked = 0; m_blocks_in_win = 0; m_bad_in_win = 0; m_ber_cycles = 0; m_ber_bad = 0;
      e_hi = 0; e_valid = 0; e_slip = 0; e_coded = '0; e_vcnt = 0; e_icnt = 0; e_loss = 0;
      return;
    end
    e_slip  = 0;
    e_valid = 0;
    if (!v) return;
    nv = 0;
    for (int k = 0; k < NB; k++) begin
      sh = d[k*FW + FW - 1 -: 2];
      if (sh == 2'b01 || sh == 2'b10) nv++;
    end
    ni = NB - nv;
    e_coded = d;
    e_vcnt += nv;
    e_icnt += ni;
    if (!m_locked) begin
      if (ni > 0) begin
        m_blocks_in_win = 0;
        e_slip = 1;
      end else if (m_blocks_in_win + NB >= LOCK_CNT) begin
        m_locked = 1; m_blocks_in_win = 0; m_bad_in_win = 0;
      end else begin
        m_blocks_in_win += NB;
      end
    end else begin
      m_blocks_in_win += NB;
      m_bad_in_win    += ni;
      m_ber_cycles    += 1;
      m_ber_bad       += ni;
      if (m_bad_in_win >= UNLOCK_BAD) begin
        m_locked = 0; e_slip = 1; e_loss++;
        m_blocks_in_win = 0; m_bad_in_win = 0; m_ber_cycles = 0; m_ber_bad = 0; e_hi = 0;
      end else begin
        if (m_blocks_in_win >= LOCK_CNT) begin
          m_blocks_in_win = 0; m_bad_in_win = 0;
        end
        if (m_ber_bad >= BER_THRESH) e_hi = 1;
        if (m_ber_cycles == BER_WINDOW) begin
          if (m_ber_bad < BER_THRESH) e_hi = 0;
          m_ber_cycles = 0; m_ber_bad = 0;
        end
      end
    end
    e_valid = m_locked;
  endtask

  always @(posedge clk) begin
    model_step(rst_n, valid, rx_coded);
    #1;
    chk("o_block_lock", o_block_lock, m_locked);
    chk("o_valid", o_valid, e_valid);
    chk("o_slip", o_slip, e_slip);
    chk("o_hi_ber", o_hi_ber, e_hi);
    chk("o_rx_coded", o_rx_coded === e_coded, 1);
    chk("o_valid_sh_count", o_valid_sh_count, e_vcnt);
    chk("o_inv_sh_count", o_inv_sh_count, e_icnt);
    chk("o_lock_loss_count", o_lock_loss_count, e_loss);
    if (o_slip === 1'b1) slip_cnt++;
  end

  function automatic logic [W-1:0] make_word(input int nbad);
    logic [W-1:0] w;
    logic [1:0]   sh;
    for (int k = 0; k < NB; k++) begin
      if (k < nbad) sh = (k % 2) ? 2'b11 : 2'b00;
      else          sh = (k % 2) ? 2'b10 : 2'b01;
      w[k*FW +: FW] = {sh, $urandom(), $urandom()};
    end
    return w;
  endfunction

  task automatic step(input logic v, input int nbad);
    valid    = v;
    rx_coded = make_word(nbad);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 0);
    step(1'b0, 0);
    rst_n = 1'b1;
    slip_cnt = 0;
  endtask

  task automatic acquire();
    for (int c = 0; c < 16; c++) step(1'b1, 0);
  endtask

  initial begin
    // Reset state and minimum lock time
    do_reset();
    chk("reset lock", o_block_lock, 0);
    chk("reset valid count", o_valid_sh_count, 0);
    chk("reset rx_coded zero", o_rx_coded == '0, 1);
    for (int c = 1; c <= 16; c++) begin
      step(1'b1, 0);
      if (c == 15) chk("t1 lock after 15", o_block_lock, 0);
    end
    chk("t1 lock after 16", o_block_lock, 1);
    chk("t1 o_valid", o_valid, 1);
    chk("t1 valid count", o_valid_sh_count, 64);
    chk("t1 no slips", slip_cnt, 0);

    // Bad header during acquisition restarts the count
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step(1'b1, (c == 10) ? 1 : 0);
      if (c == 10) chk("t2 slip at 10", o_slip, 1);
      if (c == 25) chk("t2 lock after 25", o_block_lock, 0);
    end
    chk("t2 lock after 26", o_block_lock, 1);
    chk("t2 slip count", slip_cnt, 1);
    chk("t2 inv count", o_inv_sh_count, 1);
    chk("t2 valid count", o_valid_sh_count, 103);

    // Four all-invalid cycles while locked lose lock on the fourth
    for (int c = 1; c <= 4; c++) begin
      step(1'b1, 4);
      if (c == 1) chk("t3 hi_ber after 4 bad", o_hi_ber, 0);
      if (c == 2) chk("t3 hi_ber after 8 bad", o_hi_ber, 1);
      if (c == 3) begin
        chk("t3 lock held at 12 bad", o_block_lock, 1);
        chk("t3 o_valid at 12 bad", o_valid, 1);
      end
    end
    chk("t3 unlocked", o_block_lock, 0);
    chk("t3 slip", o_slip, 1);
    chk("t3 o_valid dropped", o_valid, 0);
    chk("t3 loss count", o_lock_loss_count, 1);
    chk("t3 hi_ber cleared", o_hi_ber, 0);
    chk("t3 inv count", o_inv_sh_count, 17);
    step(1'b1, 0);
    chk("t3 slip one cycle", o_slip, 0);

    // 15 invalid per window holds lock; 16 at window completion drops it
    do_reset();
    acquire();
    for (int w = 0; w < 10; w++)
      for (int c = 0; c < 16; c++) step(1'b1, (c < 15) ? 1 : 0);
    chk("t4 lock held", o_block_lock, 1);
    chk("t4 inv count", o_inv_sh_count, 150);
    chk("t4 no loss", o_lock_loss_count, 0);
    for (int c = 0; c < 16; c++) begin
      step(1'b1, (c < 3 || c == 15) ? 4 : 0);
      if (c == 14) chk("t4 lock before window end", o_block_lock, 1);
    end
    chk("t4 unlock wins", o_block_lock, 0);
    chk("t4 loss count", o_lock_loss_count, 1);
    chk("t4 inv count final", o_inv_sh_count, 166);

    // Hi-BER windows
    do_reset();
    acquire();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, (c == 0) ? 2 : (c == 1) ? 3 : 0);
      if (c == 0) chk("t5 hi_ber below thresh", o_hi_ber, 0);
      if (c == 1) chk("t5 hi_ber at thresh", o_hi_ber, 1);
    end
    chk("t5 hi_ber kept at window end", o_hi_ber, 1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 0);
      if (c == 6) chk("t5 hi_ber held mid clean window", o_hi_ber, 1);
    end
    chk("t5 hi_ber cleared at window end", o_hi_ber, 0);
    for (int c = 0; c < 8; c++) step(1'b1, (c < 4) ? 1 : 0);
    chk("t5 hi_ber 4 bad", o_hi_ber, 0);
    for (int c = 0; c < 8; c++) step(1'b1, (c == 6) ? 1 : (c == 7) ? 4 : 0);
    chk("t5 hi_ber on last cycle", o_hi_ber, 1);
    for (int c = 0; c < 8; c++) step(1'b1, 0);
    chk("t5 hi_ber cleared again", o_hi_ber, 0);
    chk("t5 lock held", o_block_lock, 1);

    // Gaps shift acquisition; gaps hold outputs; reset while locked
    do_reset();
    for (int c = 1; c <= 19; c++) begin
      logic v;
      v = !(c == 5 || c == 9 || c == 13);
      step(v, v ? 0 : 4);
      if (c == 18) chk("t6 lock after 18", o_block_lock, 0);
    end
    chk("t6 lock after 19", o_block_lock, 1);
    chk("t6 no slips", slip_cnt, 0);
    for (int c = 0; c < 3; c++) step(1'b0, 4);
    chk("t6 gap lock held", o_block_lock, 1);
    chk("t6 gap o_valid", o_valid, 0);
    chk("t6 gap valid count", o_valid_sh_count, 64);
    step(1'b1, 3);
    step(1'b1, 3);
    chk("t6 hi_ber before reset", o_hi_ber, 1);
    rst_n = 1'b0;
    step(1'b1, 0);
    chk("t6 reset lock", o_block_lock, 0);
    chk("t6 reset hi_ber", o_hi_ber, 0);
    chk("t6 reset o_valid", o_valid, 0);
    chk("t6 reset valid count", o_valid_sh_count, 0);
    chk("t6 reset rx_coded zero", o_rx_coded == '0, 1);
    rst_n = 1'b1;
    acquire();
    chk("t6 relock", o_block_lock, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
